// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII Ethernet receive path.
package ether_pkg;

  typedef enum logic [2:0] {
    SKIP,
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    CHECK
  } state_t;

  localparam int unsigned HEADER_DIBITS  = 56;
  localparam int unsigned FCS_DIBITS     = 16;
  localparam int unsigned MIN_DIBITS     = HEADER_DIBITS + FCS_DIBITS;
  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;

  // Reflected IEEE 802.3 polynomial; rxd[0] is the earlier bit on the wire.
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;

endpackage

// File: rtl/crc32.sv
// Dibit-serial Ethernet CRC-32. axiod is the FCS as it would sit in a 16-dibit
// left-shifting line, first transmitted dibit in [31:30].
module crc32
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [31:0] axiod
);

  logic [31:0] lfsr;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 2; b++) begin
      r = (r >> 1) ^ ({32{r[0] ^ d[b]}} & CRC_POLY);
    end
    return r;
  endfunction

  // Complemented register, regrouped so the dibit sent first lands in [31:30].
  function automatic logic [31:0] wire_order(input logic [31:0] c);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[31-2*i] = ~c[2*i+1];
      o[30-2*i] = ~c[2*i];
    end
    return o;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr  <= '1;
      axiov <= 1'b0;
      axiod <= '0;
    end else begin
      if (axiiv) begin
        lfsr  <= crc_step(lfsr, axiid);
        axiov <= 1'b1;
      end
      axiod <= wire_order(lfsr);
    end
  end

endmodule

// File: rtl/ether_in.sv
// RMII receive front end: strips preamble/header, forwards payload dibits and
// reports FCS status and runt frames at the end of each frame.
module ether_in
  import ether_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE   = 16'h9000,
  parameter int unsigned FILTER_TYPE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic [15:0] ethertype,
  output logic        frame_done,
  output logic        fcs_ok,
  output logic        runt
);

  localparam logic [12:0] FcsCnt    = 13'(FCS_DIBITS);
  localparam logic [12:0] TypeStart = 13'(HEADER_DIBITS - 8);
  localparam logic [12:0] TypeLast  = 13'(HEADER_DIBITS - 1);
  localparam logic [12:0] MinCnt    = 13'(MIN_DIBITS);

  state_t      state;
  logic [12:0] count;
  logic [31:0] dline;
  logic [13:0] type_sh;
  logic        accept;
  logic        pass;
  logic        crc_rst;
  logic        crc_in_valid;
  logic        crc_valid;
  logic [31:0] crc_out;

  assign accept       = crsdv && (state == HEADER || state == PAYLOAD);
  assign crc_in_valid = accept && (count >= FcsCnt);
  assign crc_rst      = rst && !(state == IDLE || state == PREAMBLE);
  assign pass         = (FILTER_TYPE == 0) || (ethertype == ETHERTYPE);

  // Fed from the tail of the delay line, so the trailing FCS never enters it.
  crc32 u_crc (
    .clk   (clk),
    .rst   (crc_rst),
    .axiiv (crc_in_valid),
    .axiid (dline[31:30]),
    .axiov (crc_valid),
    .axiod (crc_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SKIP;
      count      <= '0;
      dline      <= '0;
      type_sh    <= '0;
      ethertype  <= '0;
      axiov      <= 1'b0;
      axiod      <= '0;
      frame_done <= 1'b0;
      fcs_ok     <= 1'b0;
      runt       <= 1'b0;
    end else begin
      axiov      <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        SKIP: begin
          if (!crsdv) state <= IDLE;
        end
        IDLE: begin
          if (crsdv && rxd == PREAMBLE_DIBIT) state <= PREAMBLE;
        end
        PREAMBLE: begin
          count <= '0;
          dline <= '0;
          if (!crsdv) state <= IDLE;
          else if (rxd == SFD_DIBIT) state <= HEADER;
          else if (rxd != PREAMBLE_DIBIT) state <= SKIP;
        end
        HEADER, PAYLOAD: begin
          if (!crsdv) begin
            state <= CHECK;
          end else begin
            dline <= {dline[29:0], rxd};
            if (count != '1) count <= count + 13'd1;
            if (state == HEADER && count >= TypeStart) type_sh <= {type_sh[11:0], rxd};
            if (state == HEADER && count == TypeLast) begin
              ethertype <= {type_sh, rxd};
              state     <= PAYLOAD;
            end
            // Dibit leaving the line is payload once it is past the header.
            if (count >= MinCnt && pass) begin
              axiov <= 1'b1;
              axiod <= dline[31:30];
            end
          end
        end
        CHECK: begin
          frame_done <= 1'b1;
          runt       <= (count < MinCnt);
          fcs_ok     <= (count >= MinCnt) && crc_valid && (dline == crc_out);
          state      <= IDLE;
        end
        default: state <= SKIP;
      endcase
    end
  end

endmodule

// File: tb/tb_ether_in.sv
// Bench for ether_in: directed frame table plus random frames against a
// byte-stream level model of Ethernet reception.
module tb_ether_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        crsdv = 1'b0;
  logic [1:0]  rxd = 2'b00;

  logic        axiov, frame_done, fcs_ok, runt;
  logic [1:0]  axiod;
  logic [15:0] ethertype;
  logic        axiov_a, frame_done_a, fcs_ok_a, runt_a;
  logic [1:0]  axiod_a;
  logic [15:0] ethertype_a;

  int n_checks = 0;
  int n_fail   = 0;

  ether_in dut (
    .clk        (clk),
    .rst        (rst),
    .crsdv      (crsdv),
    .rxd        (rxd),
    .axiov      (axiov),
    .axiod      (axiod),
    .ethertype  (ethertype),
    .frame_done (frame_done),
    .fcs_ok     (fcs_ok),
    .runt       (runt)
  );

  ether_in #(
    .ETHERTYPE   (16'h9000),
    .FILTER_TYPE (0)
  ) dut_all (
    .clk        (clk),
    .rst        (rst),
    .crsdv      (crsdv),
    .rxd        (rxd),
    .axiov      (axiov_a),
    .axiod      (axiod_a),
    .ethertype  (ethertype_a),
    .frame_done (frame_done_a),
    .fcs_ok     (fcs_ok_a),
    .runt       (runt_a)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled mid-cycle.
  logic [1:0] got_pay[$];
  logic [1:0] got_pay_a[$];
  int         n_done = 0;
  int         n_done_a = 0;
  logic       last_ok, last_runt, last_ok_a, last_runt_a;

  always @(negedge clk) begin
    if (axiov) got_pay.push_back(axiod);
    if (axiov_a) got_pay_a.push_back(axiod_a);
    if (frame_done) begin
      n_done++;
      last_ok   = fcs_ok;
      last_runt = runt;
    end
    if (frame_done_a) begin
      n_done_a++;
      last_ok_a   = fcs_ok_a;
      last_runt_a = runt_a;
    end
  end

  typedef struct {
    logic [15:0] et;
    int          paylen;
    int          flip;      // payload dibit to corrupt, -1 none
    int          n;         // post-SFD dibits actually sent, -1 whole frame
    bit          badpre;
    int          rst_at;    // post-SFD index carrying a reset pulse, -1 none
    bit          exp_done;
    bit          exp_ok;
    bit          exp_runt;
    int          exp_npay;
  } vec_t;

  logic [1:0]  body[$];
  logic [15:0] exp_type = 16'h0000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Standard Ethernet CRC over the first n post-SFD dibits, bits in wire order.
  function automatic logic [31:0] fcs_over(input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 2; b++) begin
        c = ((c[0] ^ body[i][b]) != 1'b0) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // FCS as received: the last 16 dibits, first wire bit is bit 0.
  function automatic logic [31:0] fcs_recv(input int n);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      f[2*i]   = body[n-16+i][0];
      f[2*i+1] = body[n-16+i][1];
    end
    return f;
  endfunction

  task automatic build(input logic [15:0] et, input int paylen, input int flip, input int n);
    logic [31:0] f;
    body.delete();
    repeat (24) body.push_back(2'b11);
    repeat (24) body.push_back(2'($urandom));
    for (int i = 7; i >= 0; i--) body.push_back(et[2*i +: 2]);
    repeat (paylen) body.push_back(2'($urandom));
    f = fcs_over(body.size());
    for (int i = 0; i < 16; i++) body.push_back({f[2*i+1], f[2*i]});
    if (flip >= 0) body[56+flip] = body[56+flip] ^ 2'b01;
    if (n >= 0) while (body.size() > n) void'(body.pop_back());
  endtask

  task automatic drive(input logic [1:0] d);
    @(posedge clk);
    #1;
    crsdv = 1'b1;
    rxd   = d;
  endtask

  function automatic vec_t mk(input logic [15:0] et, input int paylen, input int flip,
                              input int n, input bit badpre, input int rst_at,
                              input bit d, input bit ok, input bit rn, input int np);
    vec_t v;
    v.et = et; v.paylen = paylen; v.flip = flip; v.n = n; v.badpre = badpre;
    v.rst_at = rst_at; v.exp_done = d; v.exp_ok = ok; v.exp_runt = rn; v.exp_npay = np;
    return v;
  endfunction

  task automatic run_frame(input vec_t v, input bit use_table, input string tag);
    int         n, eff, m_npay_all, m_npay, bad;
    int         base_p, base_pa, base_d, base_da;
    bit         m_done, m_ok, m_runt, e_done, e_ok, e_runt;
    int         e_npay;
    logic [1:0] pre[8];

    build(v.et, v.paylen, v.flip, v.n);
    n = body.size();

    m_done = !v.badpre && v.rst_at < 0;
    m_runt = n < 72;
    m_ok   = 1'b0;
    if (!m_runt) m_ok = (fcs_over(n - 16) == fcs_recv(n));
    eff        = v.badpre ? 0 : ((v.rst_at >= 0) ? v.rst_at : n);
    m_npay_all = (eff > 72) ? eff - 72 : 0;
    m_npay     = (v.et == 16'h9000) ? m_npay_all : 0;
    if (v.rst_at >= 0) exp_type = 16'h0000;
    else if (!v.badpre && n >= 56) exp_type = v.et;

    if (use_table) begin
      e_done = v.exp_done; e_ok = v.exp_ok; e_runt = v.exp_runt; e_npay = v.exp_npay;
    end else begin
      e_done = m_done; e_ok = m_ok; e_runt = m_runt; e_npay = m_npay;
    end

    base_p  = got_pay.size();
    base_pa = got_pay_a.size();
    base_d  = n_done;
    base_da = n_done_a;

    pre = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
    if (v.badpre) pre[2] = 2'b10;
    foreach (pre[i]) drive(pre[i]);
    for (int i = 0; i < n; i++) begin
      drive(body[i]);
      if (i == v.rst_at) begin
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check({tag, "_rst_outputs"}, {10'd0, axiov, axiod, ethertype, frame_done, fcs_ok, runt},
              32'd0);
        check({tag, "_rst_outputs_all"},
              {10'd0, axiov_a, axiod_a, ethertype_a, frame_done_a, fcs_ok_a, runt_a}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    crsdv = 1'b0;
    rxd   = 2'b00;
    repeat (8) @(negedge clk);

    check({tag, "_done"}, n_done - base_d, 32'(e_done));
    if (e_done) begin
      check({tag, "_fcs_ok"}, 32'(last_ok), 32'(e_ok));
      check({tag, "_runt"}, 32'(last_runt), 32'(e_runt));
    end
    check({tag, "_npay"}, got_pay.size() - base_p, e_npay);
    if (e_npay > 0) begin
      bad = 0;
      for (int i = 0; i < e_npay && base_p + i < got_pay.size(); i++)
        if (got_pay[base_p+i] !== body[56+i]) bad++;
      check({tag, "_pay_bad_dibits"}, bad, 0);
    end
    check({tag, "_ethertype"}, 32'(ethertype), 32'(exp_type));

    check({tag, "_all_done"}, n_done_a - base_da, 32'(m_done));
    if (m_done) check({tag, "_all_ok_runt"}, {30'd0, last_ok_a, last_runt_a}, {30'd0, m_ok, m_runt});
    check({tag, "_all_npay"}, got_pay_a.size() - base_pa, m_npay_all);
    if (m_npay_all > 0) begin
      bad = 0;
      for (int i = 0; i < m_npay_all && base_pa + i < got_pay_a.size(); i++)
        if (got_pay_a[base_pa+i] !== body[56+i]) bad++;
      check({tag, "_all_pay_bad_dibits"}, bad, 0);
    end
    check({tag, "_all_ethertype"}, 32'(ethertype_a), 32'(exp_type));
  endtask

  vec_t tbl[12];

  initial begin
    //             et        pay flip  n   bad rst   done ok runt npay
    tbl[0]  = mk(16'h9000, 64, -1, -1, 0, -1, 1, 1, 0, 64);
    tbl[1]  = mk(16'h9000, 64,  5, -1, 0, -1, 1, 0, 0, 64);
    tbl[2]  = mk(16'h0800, 64, -1, -1, 0, -1, 1, 1, 0, 0);
    tbl[3]  = mk(16'h9000, 64, -1, 40, 0, -1, 1, 0, 1, 0);
    tbl[4]  = mk(16'h9000, 64, -1, -1, 1, -1, 0, 0, 0, 0);
    tbl[5]  = mk(16'h9000, 64, -1, -1, 0, -1, 1, 1, 0, 64);
    tbl[6]  = mk(16'h9000, 64, -1, -1, 0, 76, 0, 0, 0, 4);
    tbl[7]  = mk(16'h9000, 64, -1, -1, 0, -1, 1, 1, 0, 64);
    tbl[8]  = mk(16'h9000,  0, -1, -1, 0, -1, 1, 1, 0, 0);
    tbl[9]  = mk(16'h9000,  0, -1, 71, 0, -1, 1, 0, 1, 0);
    tbl[10] = mk(16'h9000,  1, -1, -1, 0, -1, 1, 1, 0, 1);
    tbl[11] = mk(16'h9000, 64, -1, 56, 0, -1, 1, 0, 1, 0);

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {10'd0, axiov, axiod, ethertype, frame_done, fcs_ok, runt}, 32'd0);
    check("reset_outputs_all",
          {10'd0, axiov_a, axiod_a, ethertype_a, frame_done_a, fcs_ok_a, runt_a}, 32'd0);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 12; k++) run_frame(tbl[k], 1'b1, $sformatf("vec%0d", k));

    for (int k = 0; k < 24; k++) begin
      vec_t v;
      v = mk(16'h9000, 0, -1, -1, 0, -1, 0, 0, 0, 0);
      if ($urandom_range(0, 1) == 0) v.et = 16'($urandom);
      v.paylen = int'($urandom_range(0, 90));
      if (v.paylen > 0 && $urandom_range(0, 3) == 0) v.flip = int'($urandom_range(0, v.paylen - 1));
      if ($urandom_range(0, 3) == 0) v.n = int'($urandom_range(0, 72 + v.paylen));
      run_frame(v, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ether_in.md
ETHER_IN -- requirements
Module: ether_in

Interface
REQ-001 Parameter ETHERTYPE, default 16'h9000, ethertype whose payload is forwarded.
REQ-002 Parameter FILTER_TYPE, default 1, 1 = forward payload only on ethertype match; 0 = forward all payloads.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 crsdv  input  1  RMII carrier/data valid, treated as clean frame-valid.
REQ-006 rxd  input  2  RMII receive dibit, valid when crsdv=1.
REQ-007 axiov  output  1  payload dibit valid.
REQ-008 axiod  output  2  payload dibit, in arrival order.
REQ-009 ethertype  output  16  last captured ethertype, held until the next capture.
REQ-010 frame_done  output  1  one-cycle pulse at the end of every frame that passed SFD.
REQ-011 fcs_ok  output  1  valid with frame_done; 1 = received FCS equals computed CRC.
REQ-012 runt  output  1  valid with frame_done; 1 = frame ended before 72 post-SFD dibits.

Function
REQ-013 The FSM SHALL have states SKIP, IDLE, PREAMBLE, HEADER, PAYLOAD, CHECK.
REQ-014 SKIP: remain while crsdv=1; crsdv=0 -> IDLE.
REQ-015 IDLE: crsdv=1 and rxd=2'b01 -> PREAMBLE; otherwise stay.
REQ-016 PREAMBLE: rxd=2'b01 stay; rxd=2'b11 (SFD) -> HEADER; other dibit -> SKIP; crsdv=0 -> IDLE. No frame_done in any of these cases.
REQ-017 Post-SFD dibits SHALL be counted from 0 by a 13-bit counter saturating at 8191. Dibits 0-23 are the destination MAC, 24-47 the source MAC, 48-55 the ethertype, and 56 onward are the payload plus FCS.
REQ-018 Ethertype dibits SHALL be shifted in MSB-first (left shift, new dibit into [1:0]). The ethertype output updates on the cycle dibit 55 is accepted.
REQ-019 Every post-SFD dibit SHALL enter a 16-dibit (32-bit) delay line. The dibit leaving the line SHALL feed crc32; FCS dibits therefore never reach the CRC.
REQ-020 A dibit leaving the line with index >=56 SHALL drive axiod with axiov=1, gated by an ethertype match when FILTER_TYPE=1. Latency from rxd to axiod is 16 cycles plus 1 register.
REQ-021 HEADER -> PAYLOAD when dibit 55 is accepted.
REQ-022 crsdv falling in HEADER or PAYLOAD -> CHECK. The delay line then holds the FCS, with the first received dibit in [31:31-1].
REQ-023 CHECK lasts 1 cycle, waiting for the crc32 output to settle, then asserts frame_done for 1 cycle and returns to IDLE.
REQ-024 fcs_ok = (delay line == crc32 output) and not runt.
REQ-025 runt = 1 if fewer than 72 dibits followed the SFD; then fcs_ok = 0 and no payload is emitted.
REQ-026 crc32 SHALL be reset in IDLE and PREAMBLE so that it covers destination MAC through payload only.
REQ-027 When crsdv falls, axiov SHALL deassert the next cycle; undrained delay-line content is FCS and is never output.
REQ-028 crsdv rising in CHECK SHALL be ignored; the frame is lost and the FSM reaches IDLE, then SKIP rules do not apply (IDLE handles it).

Reset
REQ-029 rst=0 SHALL asynchronously clear axiov, axiod, ethertype, frame_done, fcs_ok, runt, the counter, and the delay line to 0, and force state SKIP.
REQ-030 Reset mid-frame: the remainder of that frame SHALL be discarded, with no frame_done, until crsdv=0.

Structure
REQ-031 Package ether_pkg SHALL hold the state enum, HEADER_DIBITS=56, FCS_DIBITS=16, PREAMBLE_DIBIT=2'b01, and SFD_DIBIT=2'b11.
REQ-032 ether_in SHALL instantiate exactly one existing crc32 (clk, rst, axiiv, axiid, axiov, axiod[31:0]), with its reset active during IDLE and PREAMBLE or rst=0.

Verification
REQ-033 Frame of 7x2'b01, 2'b11, bcast MAC, src MAC, type 16'h9000, 64 payload dibits, correct FCS -> 64 axiov cycles with payload dibits in order, frame_done with fcs_ok=1 and runt=0, ethertype=16'h9000.
REQ-034 Same frame with one payload dibit flipped -> 64 payload dibits output, frame_done with fcs_ok=0.
REQ-035 Same frame with type 16'h0800 and FILTER_TYPE=1 -> axiov never 1, frame_done with fcs_ok=1, ethertype=16'h0800.
REQ-036 crsdv drops after 40 post-SFD dibits -> frame_done with runt=1, fcs_ok=0, no axiov.
REQ-037 Preamble containing a 2'b10 dibit -> no frame_done, no axiov; a following valid frame is received correctly.
REQ-038 rst=0 for 1 cycle at payload dibit 20 -> outputs 0 immediately, no frame_done for that frame, next frame received with fcs_ok=1.
